// File: rtl/uart_pkg.sv
// uart_pkg -- shared state encodings and frame constants for the UART responder.
// Revision 1.0
`default_nettype none

package uart_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TX_RUN  = 2'd1,
      RX_WAIT = 2'd2,
      DONE    = 2'd3
   } ctl_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   localparam logic RORS_SEND = 1'b1;
   localparam logic RORS_RECV = 1'b0;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx -- free-running 8N1 receiver with input synchroniser and glitch rejection.
// Revision 1.0
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       push,
   output logic       ferr
);

   localparam int             CW        = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);

   rx_state_t       state, state_nx;
   logic            sync1, sync2, sync_q;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [2:0]      bitn, bitn_nx;
   logic [7:0]      shreg, shreg_nx;
   logic            push_nx, ferr_nx;

   assign data = shreg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         sync_q <= 1'b1;
         state  <= RX_IDLE;
         cnt    <= '0;
         bitn   <= '0;
         shreg  <= '0;
         push   <= 1'b0;
         ferr   <= 1'b0;
      end else begin
         sync1  <= rxd;
         sync2  <= sync1;
         sync_q <= sync2;
         state  <= state_nx;
         cnt    <= cnt_nx;
         bitn   <= bitn_nx;
         shreg  <= shreg_nx;
         push   <= push_nx;
         ferr   <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      bitn_nx  = bitn;
      shreg_nx = shreg;
      push_nx  = 1'b0;
      ferr_nx  = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_nx = '0;
            // Edge, not level: a line left low by a bad stop bit must not re-trigger
            if (sync_q && !sync2) state_nx = RX_START;
         end
         RX_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nx   = '0;
               bitn_nx  = '0;
               state_nx = (sync2 == START_BIT) ? RX_DATA : RX_IDLE;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx   = '0;
               shreg_nx = {sync2, shreg[7:1]};
               bitn_nx  = bitn + 1'b1;
               if (bitn == DATA_LAST) state_nx = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_LAST) begin
               state_nx = RX_IDLE;
               if (sync2 == STOP_BIT) push_nx = 1'b1;
               else                   ferr_nx = 1'b1;
            end
         end
         default: state_nx = RX_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/uart_ctl.sv
// uart_ctl -- byte-I/O responder: 8N1 transmitter, receive FIFO and request/done control FSM.
// Revision 1.0
`default_nettype none

module uart_ctl
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 868,
   parameter int RX_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       uart_go,
   input  logic       rors,
   input  logic [7:0] tx_byte,
   output logic [7:0] rx_byte,
   output logic       uart_done,
   output logic       txd,
   input  logic       rxd,
   output logic       frame_err,
   output logic       overrun
);

   localparam int             AW         = $clog2(RX_DEPTH);
   localparam int             CW         = $clog2(CLK_PER_BIT);
   localparam int             FRAME_BITS = DATA_BITS + 2;
   localparam logic [CW-1:0]  BAUD_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [3:0]     LAST_BIT   = 4'(FRAME_BITS - 1);

   ctl_state_t              state, state_nx;
   logic [FRAME_BITS-1:0]   tx_sh;
   logic [3:0]              bit_cnt;
   logic [CW-1:0]           baud;
   logic                    done_nx, tx_load, tx_shift, pop;

   logic [7:0]              mem [RX_DEPTH];
   logic [AW:0]             wr_ptr, rd_ptr;
   logic                    fifo_empty, fifo_full, push_ok;

   logic [7:0]              rx_data;
   logic                    rx_push, rx_ferr;

   uart_rx #(
      .CLK_PER_BIT (CLK_PER_BIT)
   ) u_rx (
      .clk  (clk),
      .rstn (rstn),
      .rxd  (rxd),
      .data (rx_data),
      .push (rx_push),
      .ferr (rx_ferr)
   );

   // The shifter resets to all ones, so txd is idle-high the instant reset asserts
   assign txd = tx_sh[0];

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok    = rx_push && (!fifo_full || pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (uart_go) begin
               if (rors == RORS_SEND) begin
                  tx_load  = 1'b1;
                  state_nx = TX_RUN;
               end else begin
                  state_nx = RX_WAIT;
               end
            end
         end
         TX_RUN: begin
            if (baud == BAUD_LAST) begin
               if (bit_cnt == LAST_BIT) begin
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  tx_shift = 1'b1;
               end
            end
         end
         RX_WAIT: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               done_nx  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (!uart_go) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_sh     <= '1;
         bit_cnt   <= '0;
         baud      <= '0;
         uart_done <= 1'b0;
      end else begin
         uart_done <= done_nx;
         if (tx_load) begin
            tx_sh   <= {STOP_BIT, tx_byte, START_BIT};
            bit_cnt <= '0;
            baud    <= '0;
         end else if (state == TX_RUN) begin
            baud <= (baud == BAUD_LAST) ? '0 : baud + 1'b1;
            if (tx_shift) begin
               tx_sh   <= {STOP_BIT, tx_sh[FRAME_BITS-1:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rx_byte   <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rx_byte <= mem[rd_ptr[AW-1:0]];
         end
         if (rx_ferr)             frame_err <= 1'b1;
         if (rx_push && !push_ok) overrun   <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_ctl.sv
// tb_uart_ctl -- directed bench with a frame-level model of txd, done timing and the receive FIFO.
// Revision 1.0
`default_nettype none

module tb_uart_ctl;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       uart_go = 1'b0;
   logic       rors = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       rxd = 1'b1;
   logic [7:0] rx_byte;
   logic       uart_done;
   logic       txd;
   logic       frame_err;
   logic       overrun;

   uart_ctl #(
      .CLK_PER_BIT (CPB),
      .RX_DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .uart_go   (uart_go),
      .rors      (rors),
      .tx_byte   (tx_byte),
      .rx_byte   (rx_byte),
      .uart_done (uart_done),
      .txd       (txd),
      .rxd       (rxd),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model state: current transmit frame, the window in which the next done may appear,
   // the byte that done must deliver, and a queue standing in for the receive FIFO.
   bit         tx_act = 1'b0;
   int         tx_a = 0;
   logic [9:0] tx_frame = 10'h3FF;
   int         dn_lo = -1;
   int         dn_hi = -1;
   int         dn_at = -1;
   bit         dn_seen = 1'b1;
   bit         dn_rx = 1'b0;
   logic [7:0] dn_byte = 8'h00;
   logic [7:0] exp_rxb = 8'h00;
   bit         rx_pend = 1'b0;
   bit         ovr_exp = 1'b0;
   int         rq_a = 0;
   logic [7:0] q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   initial begin
      logic exp_txd;
      bit   in_win;
      forever begin
         @(negedge clk);
         exp_txd = 1'b1;
         if (rstn && tx_act && cyc >= tx_a + 1 && cyc <= tx_a + FRAME)
            exp_txd = tx_frame[(cyc - tx_a - 1) / CPB];
         check("txd", txd, exp_txd);
         in_win = !dn_seen && dn_lo >= 0 && cyc >= dn_lo && cyc <= dn_hi;
         if (in_win && uart_done === 1'b1) begin
            dn_seen = 1'b1;
            dn_at   = cyc;
            if (dn_rx) exp_rxb = dn_byte;
         end else if (!in_win) begin
            check("uart_done", uart_done, 1'b0);
         end else if (cyc == dn_hi) begin
            check("uart_done_missing", uart_done, 1'b1);
            dn_seen = 1'b1;
         end
         check("rx_byte", rx_byte, exp_rxb);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (!dn_seen && k < bound) begin
         tick();
         k++;
      end
      n_cmp++;
      if (!dn_seen) begin
         n_fail++;
         $display("FAIL done_timeout: no uart_done within %0d cycles at cycle %0d", bound, cyc);
         dn_seen = 1'b1;
      end
   endtask

   task automatic start_send(input logic [7:0] b);
      tick();
      uart_go  = 1'b1;
      rors     = 1'b1;
      tx_byte  = b;
      tx_a     = cyc;
      tx_frame = {1'b1, b, 1'b0};
      tx_act   = 1'b1;
      dn_lo    = cyc + FRAME + 1;
      dn_hi    = dn_lo;
      dn_rx    = 1'b0;
      dn_seen  = 1'b0;
   endtask

   task automatic do_send(input logic [7:0] b, input int hold, input bit use_lit,
                          input logic [9:0] lit);
      start_send(b);
      if (hold == 0) begin
         tick();
         uart_go = 1'b0;
         tx_byte = ~b;
      end
      for (int k = 0; k < 10; k++) begin
         while (cyc < tx_a + 2 + CPB * k) tick();
         if (use_lit) check("txd_literal", txd, lit[k]);
      end
      wait_done(FRAME + 10);
      repeat (hold) tick();
      uart_go = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_recv(input bit hold);
      tick();
      uart_go = 1'b1;
      rors    = 1'b0;
      rq_a    = cyc;
      dn_seen = 1'b0;
      dn_rx   = 1'b1;
      if (q.size() > 0) begin
         dn_byte = q.pop_front();
         dn_lo   = cyc + 2;
         dn_hi   = cyc + 2;
      end else begin
         rx_pend = 1'b1;
         dn_lo   = -1;
      end
      if (!hold) begin
         tick();
         uart_go = 1'b0;
      end
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      int r;
      f = {stop, b, 1'b0};
      tick();
      r = cyc;
      for (int k = 0; k < 10; k++) begin
         rxd = f[k];
         repeat (CPB) tick();
      end
      rxd = 1'b1;
      if (stop) begin
         if (rx_pend) begin
            rx_pend = 1'b0;
            dn_byte = b;
            dn_lo   = r + FRAME - 3;
            dn_hi   = r + FRAME + 8;
         end else if (q.size() < DEPTH) begin
            q.push_back(b);
         end else begin
            ovr_exp = 1'b1;
         end
      end
      repeat (4) tick();
   endtask

   initial begin
      #1 rstn = 1'b0;
      repeat (3) tick();
      check("reset_txd", txd, 1'b1);
      check("reset_done", uart_done, 1'b0);
      check("reset_rx_byte", rx_byte, 8'h00);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      rstn = 1'b1;
      repeat (2) tick();

      do_send(8'hA5, 0, 1'b1, 10'b1101001010);
      check("tx_latency", dn_at - tx_a, 41);
      check("txd_idle_after", txd, 1'b1);

      drive_rx(8'h3C, 1'b1);
      do_recv(1'b0);
      wait_done(10);
      check("rx_prebuf_latency", dn_at - rq_a, 2);
      check("rx_prebuf_byte", rx_byte, 8'h3C);
      repeat (3) tick();

      rxd = 1'b0;
      tick();
      rxd = 1'b1;
      repeat (20) tick();
      check("glitch_frame_err", frame_err, 1'b0);
      check("glitch_overrun", overrun, 1'b0);

      drive_rx(8'h55, 1'b0);
      check("frame_err_set", frame_err, 1'b1);

      for (int i = 1; i <= 5; i++) drive_rx(8'(i), 1'b1);
      check("overrun_model", overrun, ovr_exp);
      check("overrun_set", overrun, 1'b1);

      for (int i = 0; i < 4; i++) begin
         do_recv(1'b0);
         wait_done(10);
         check("fifo_order", rx_byte, 32'(i + 1));
         repeat (2) tick();
      end

      do_recv(1'b1);
      repeat (30) tick();
      check("blocked_no_done", dn_seen, 1'b0);
      drive_rx(8'h81, 1'b1);
      wait_done(20);
      check("rx_block_byte", rx_byte, 8'h81);
      repeat (10) tick();
      uart_go = 1'b0;
      repeat (3) tick();

      do_send(8'hC3, 10, 1'b0, 10'h000);
      check("held_send_txd", txd, 1'b1);

      start_send(8'h5A);
      tick();
      uart_go = 1'b0;
      while (cyc < tx_a + 14) tick();
      check("txd_bit3_before_reset", txd, 1'b0);
      rstn    = 1'b0;
      tx_act  = 1'b0;
      dn_seen = 1'b1;
      exp_rxb = 8'h00;
      ovr_exp = 1'b0;
      q.delete();
      #1;
      check("txd_async_reset", txd, 1'b1);
      check("done_async_reset", uart_done, 1'b0);
      repeat (3) tick();
      rstn = 1'b1;
      check("post_reset_frame_err", frame_err, 1'b0);
      check("post_reset_overrun", overrun, 1'b0);
      check("post_reset_rx_byte", rx_byte, 8'h00);
      repeat (60) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
